// File: rtl/cordic_angle_frontend.sv
// Angle front end for a CORDIC sin/cos core: folds [-pi,+pi] into [-pi/2,+pi/2],
// issues the core, and sign-corrects its results. Optional macro: CORDIC_TIMEOUT_EN.
module cordic_angle_frontend #(
  parameter int PI_Q16      = 205887,
  parameter int HALF_PI_Q16 = 102944
`ifdef CORDIC_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [18:0] angle_in,
  output logic        busy,
  output logic        res_valid,
  output logic [17:0] res_cos,
  output logic [17:0] res_sin,
  output logic        range_err,
  output logic        timeout_err,
  output logic [17:0] cordic_angle,
  output logic        cordic_init,
  input  logic [17:0] cordic_cos,
  input  logic [17:0] cordic_sin,
  input  logic        cordic_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam logic signed [18:0] C_PI      = 19'(PI_Q16);
  localparam logic signed [18:0] C_PI_N    = 19'(-PI_Q16);
  localparam logic signed [18:0] C_HALF    = 19'(HALF_PI_Q16);
  localparam logic signed [18:0] C_HALF_N  = 19'(-HALF_PI_Q16);
  localparam logic        [17:0] C_PI_18   = 18'(PI_Q16);

  state_t      r_state;
  logic        r_busy;
  logic        r_res_valid;
  logic [17:0] r_res_cos;
  logic [17:0] r_res_sin;
  logic        r_range_err;
  logic [17:0] r_cordic_angle;
  logic        r_init;
  logic        r_negate;
  logic        r_done_q;

  logic signed [18:0] w_a;
  logic        [17:0] w_reduced;
  logic               w_negate;
  logic               w_out_of_range;
  logic               w_done_rise;
  logic        [17:0] w_cos_fix;
  logic        [17:0] w_sin_fix;

  assign w_a = angle_in;

  // The folded result always fits 18 bits, so the add/sub is done modulo 2^18.
  always_comb begin
    w_reduced = angle_in[17:0];
    w_negate  = 1'b0;
    if (w_a > C_HALF) begin
      w_reduced = angle_in[17:0] - C_PI_18;
      w_negate  = 1'b1;
    end else if (w_a < C_HALF_N) begin
      w_reduced = angle_in[17:0] + C_PI_18;
      w_negate  = 1'b1;
    end
  end

  assign w_out_of_range = (w_a > C_PI) || (w_a < C_PI_N);
  assign w_done_rise    = cordic_done && !r_done_q;
  assign w_cos_fix      = r_negate ? -cordic_cos : cordic_cos;
  assign w_sin_fix      = r_negate ? -cordic_sin : cordic_sin;

`ifdef CORDIC_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] C_TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_timeout_err;
  assign timeout_err = r_timeout_err;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_busy         <= 1'b0;
      r_res_valid    <= 1'b0;
      r_res_cos      <= '0;
      r_res_sin      <= '0;
      r_range_err    <= 1'b0;
      r_cordic_angle <= '0;
      r_init         <= 1'b0;
      r_negate       <= 1'b0;
      r_done_q       <= 1'b0;
`ifdef CORDIC_TIMEOUT_EN
      r_tmo_cnt      <= '0;
      r_timeout_err  <= 1'b0;
`endif
    end else begin
      r_done_q    <= cordic_done;
      r_res_valid <= 1'b0;
      r_range_err <= 1'b0;
      r_init      <= 1'b0;
`ifdef CORDIC_TIMEOUT_EN
      r_timeout_err <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_out_of_range) begin
              r_range_err <= 1'b1;
            end else begin
              r_cordic_angle <= w_reduced;
              r_negate       <= w_negate;
              r_busy         <= 1'b1;
              r_init         <= 1'b1;
              r_state        <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT;
`ifdef CORDIC_TIMEOUT_EN
          r_tmo_cnt <= '0;
`endif
        end
        S_WAIT: begin
          if (w_done_rise) begin
            r_res_cos   <= w_cos_fix;
            r_res_sin   <= w_sin_fix;
            r_res_valid <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
`ifdef CORDIC_TIMEOUT_EN
          else if (r_tmo_cnt == C_TMO_LAST) begin
            r_timeout_err <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= S_IDLE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
          end
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy         = r_busy;
  assign res_valid    = r_res_valid;
  assign res_cos      = r_res_cos;
  assign res_sin      = r_res_sin;
  assign range_err    = r_range_err;
  assign cordic_angle = r_cordic_angle;
  assign cordic_init  = r_init;

endmodule

// File: tb/tb_cordic_angle_frontend.sv
// Directed bench for cordic_angle_frontend; the core is mocked by driving cordic_* directly.
module tb_cordic_angle_frontend;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [18:0] angle_in;
  logic        busy;
  logic        res_valid;
  logic [17:0] res_cos;
  logic [17:0] res_sin;
  logic        range_err;
  logic        timeout_err;
  logic [17:0] cordic_angle;
  logic        cordic_init;
  logic [17:0] cordic_cos;
  logic [17:0] cordic_sin;
  logic        cordic_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cordic_angle_frontend dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .angle_in     (angle_in),
    .busy         (busy),
    .res_valid    (res_valid),
    .res_cos      (res_cos),
    .res_sin      (res_sin),
    .range_err    (range_err),
    .timeout_err  (timeout_err),
    .cordic_angle (cordic_angle),
    .cordic_init  (cordic_init),
    .cordic_cos   (cordic_cos),
    .cordic_sin   (cordic_sin),
    .cordic_done  (cordic_done)
  );

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Accepts a start; returns at the negedge where the ISSUE cycle is visible.
  task automatic launch(input logic [18:0] a);
    angle_in = a;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  // Called in WAIT: raises done with the mock results and checks the result cycle.
  task automatic finish_op(input string tag, input logic [17:0] mc, input logic [17:0] ms,
                           input logic signed [31:0] ec, input logic signed [31:0] es,
                           input bit keep_done);
    cordic_cos  = mc;
    cordic_sin  = ms;
    cordic_done = 1'b1;
    tick();
    check({tag, "_valid"}, res_valid, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_cos"}, $signed(res_cos), ec);
    check({tag, "_sin"}, $signed(res_sin), es);
    if (!keep_done) cordic_done = 1'b0;
    tick();
    check({tag, "_valid_off"}, res_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bit seen;
    rst_n = 1'b0; start = 1'b0; angle_in = '0;
    cordic_cos = '0; cordic_sin = '0; cordic_done = 1'b0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_valid", res_valid, 0);
    check("rst_init", cordic_init, 0);
    check("rst_rerr", range_err, 0);
    check("rst_terr", timeout_err, 0);
    check("rst_cos", $signed(res_cos), 0);
    check("rst_sin", $signed(res_sin), 0);
    check("rst_ang", $signed(cordic_angle), 0);
    rst_n = 1'b1;
    tick();

    // 1.2 rad: in range, passed straight through
    launch(19'h13333);
    check("t1_init", cordic_init, 1);
    check("t1_busy", busy, 1);
    check("t1_ang", $signed(cordic_angle), 32'h13333);
    tick();
    check("t1_init_off", cordic_init, 0);
    check("t1_busy_wait", busy, 1);
    finish_op("t1", 18'h05CC1, 18'h0EE99, 32'h05CC1, 32'h0EE99, 0);

    // +/-2.5 rad folded by pi, results negated
    launch(19'(163840));
    check("t2p_ang", $signed(cordic_angle), -42047);
    tick();
    finish_op("t2p", 18'(1000), 18'(-2000), -1000, 2000, 0);
    launch(19'(-163840));
    check("t2n_ang", $signed(cordic_angle), 42047);
    tick();
    finish_op("t2n", 18'(1000), 18'(-2000), -1000, 2000, 0);

    // boundaries
    launch(19'(102944));
    check("t3h_ang", $signed(cordic_angle), 102944);
    tick();
    finish_op("t3h", 18'(500), 18'(-600), 500, -600, 0);
    launch(19'(205887));
    check("t3p_ang", $signed(cordic_angle), 0);
    tick();
    finish_op("t3p", 18'(65536), 18'(0), -65536, 0, 0);
    launch(19'(-205887));
    check("t3m_ang", $signed(cordic_angle), 0);
    tick();
    finish_op("t3m", 18'(-65536), 18'(100), 65536, -100, 0);

    launch(19'(205888));
    check("rng_p_err", range_err, 1);
    check("rng_p_init", cordic_init, 0);
    check("rng_p_busy", busy, 0);
    check("rng_p_ang", $signed(cordic_angle), 0);
    tick();
    check("rng_p_err_off", range_err, 0);
    check("rng_p_busy2", busy, 0);
    launch(19'(-205888));
    check("rng_n_err", range_err, 1);
    check("rng_n_init", cordic_init, 0);
    tick();

    // start while busy is ignored, including an out-of-range one
    launch(19'(1000));
    tick();
    launch(19'(2000));
    check("t4_ign_ang", $signed(cordic_angle), 1000);
    check("t4_ign_busy", busy, 1);
    check("t4_ign_init", cordic_init, 0);
    launch(19'(210000));
    check("t4_ign_rerr", range_err, 0);
    finish_op("t4a", 18'(10), 18'(20), 10, 20, 1);

    // done held high across WAIT entry must not complete the op
    launch(19'(3000));
    check("t4b_init", cordic_init, 1);
    repeat (4) tick();
    check("t4b_held_valid", res_valid, 0);
    check("t4b_held_busy", busy, 1);
    cordic_done = 1'b0;
    tick();
    check("t4b_low_valid", res_valid, 0);
    cordic_cos = 18'(7); cordic_sin = 18'(8); cordic_done = 1'b1;
    tick();
    check("t4b_valid", res_valid, 1);
    check("t4b_cos", $signed(res_cos), 7);
    check("t4b_sin", $signed(res_sin), 8);

    // start in the res_valid cycle
    launch(19'(-150000));
    check("t4c_busy", busy, 1);
    check("t4c_init", cordic_init, 1);
    check("t4c_ang", $signed(cordic_angle), 55887);
    check("t4c_valid_off", res_valid, 0);
    cordic_done = 1'b0;
    tick();
    finish_op("t4c", 18'(100), 18'(-100), -100, 100, 0);

    // reset during WAIT, then a done edge
    launch(19'(5000));
    tick();
    check("t5_busy", busy, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    cordic_cos = 18'(9); cordic_sin = 18'(9); cordic_done = 1'b1;
    tick();
    check("t5_valid", res_valid, 0);
    tick();
    check("t5_valid2", res_valid, 0);
    check("t5_busy_off", busy, 0);
    check("t5_cos", $signed(res_cos), 0);
    check("t5_sin", $signed(res_sin), 0);
    check("t5_ang", $signed(cordic_angle), 0);
    check("t5_init", cordic_init, 0);
    cordic_done = 1'b0;
    tick();

    launch(19'(7000));
    tick();
    seen = 1'b0;
`ifdef CORDIC_TIMEOUT_EN
    // WAIT entered; abort expected 64 cycles later
    repeat (63) begin
      tick();
      if (timeout_err || !busy) seen = 1'b1;
    end
    check("tmo_early", seen, 0);
    tick();
    check("tmo_err", timeout_err, 1);
    check("tmo_busy", busy, 0);
    check("tmo_valid", res_valid, 0);
    check("tmo_cos", $signed(res_cos), 0);
    tick();
    check("tmo_err_off", timeout_err, 0);
`else
    repeat (100) begin
      tick();
      if (timeout_err || !busy) seen = 1'b1;
    end
    check("notmo_wait", seen, 0);
    finish_op("notmo", 18'(1), 18'(2), 1, 2, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
